// File: rtl/id_stage_hs_pkg.sv
// Shared decode definitions: RV32I/RV64I opcodes, ALU operation classes and the control bundle
// that the ID stage hands to the EX stage.
package id_stage_hs_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNC   = 2'b10,
        ALU_UPPER  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    aluSrc;
        logic    memToReg;
        logic    regWrite;
        logic    memRead;
        logic    memWrite;
        logic    branch;
        logic    jump;
        alu_op_e aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic usesRs1(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH, OP_JALR: used = 1'b1;
            default:                                               used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic usesRs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_STORE, OP_OP, OP_BRANCH: used = 1'b1;
            default:                    used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic writesRd(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_LOAD, OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: used = 1'b1;
            default:                                                   used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/id_stage_hs_reg_file.sv
// Architectural register file: two combinational read ports, one write port from WB, x0 hard zero.
// Build option WB_BYPASS_EN makes a same-cycle write visible on the read ports (write-through).
module reg_file
    import id_stage_hs_pkg::*;
#(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] rs1_addr_i,
    input  logic [RA_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wbActive;

    assign wbActive = wb_we_i && (wb_rd_i != '0);

    // Entry 0 is never written, so it keeps reading back as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wbActive) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_data_o = (wbActive && (wb_rd_i == rs1_addr_i)) ? wb_data_i : regs_q[rs1_addr_i];
    assign rs2_data_o = (wbActive && (wb_rd_i == rs2_addr_i)) ? wb_data_i : regs_q[rs2_addr_i];
`else
    assign rs1_data_o = regs_q[rs1_addr_i];
    assign rs2_data_o = regs_q[rs2_addr_i];
`endif

endmodule

// File: rtl/id_stage_hs.sv
// Decode stage: RV32I/RV64I decode, immediate generation, register read and the ID/EX register
// with valid/ready handshake, flush and load-use stall. WB_BYPASS_EN selects a write-through regfile.
module id_stage_hs
    import id_stage_hs_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            valid_out,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] rd,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] pc_out,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic [1:0]      alu_op,
    output logic            illegal
);

    logic [6:0]        opcode;
    logic [4:0]        rs1Field;
    logic [4:0]        rs2Field;
    logic [4:0]        rdField;
    logic [RA_W-1:0]   rs1Dec;
    logic [RA_W-1:0]   rs2Dec;
    logic [RA_W-1:0]   rdDec;
    logic [XLEN-1:0]   rs1Read;
    logic [XLEN-1:0]   rs2Read;

    logic signed [31:0] immI;
    logic signed [31:0] immS;
    logic signed [31:0] immB;
    logic signed [31:0] immU;
    logic signed [31:0] immJ;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    immDec;
    ctrl_t              ctrlDec;
    logic               opLegal;
    logic               regLegal;
    logic               illegalDec;

    logic               loadUse;
    logic               advance;

    logic               valid_q,    valid_d;
    ctrl_t              ctrl_q,     ctrl_d;
    logic               illegal_q,  illegal_d;
    logic [XLEN-1:0]    imm_q,      imm_d;
    logic [XLEN-1:0]    rs1Data_q,  rs1Data_d;
    logic [XLEN-1:0]    rs2Data_q,  rs2Data_d;
    logic [RA_W-1:0]    rs1_q,      rs1_d;
    logic [RA_W-1:0]    rs2_q,      rs2_d;
    logic [RA_W-1:0]    rd_q,       rd_d;
    logic [2:0]         func3_q,    func3_d;
    logic [6:0]         func7_q,    func7_d;
    logic [XLEN-1:0]    pc_q,       pc_d;

    assign opcode   = instruction[6:0];
    assign rdField  = instruction[11:7];
    assign rs1Field = instruction[19:15];
    assign rs2Field = instruction[24:20];
    assign rs1Dec   = rs1Field[RA_W-1:0];
    assign rs2Dec   = rs2Field[RA_W-1:0];
    assign rdDec    = rdField[RA_W-1:0];

    assign immI = {{20{instruction[31]}}, instruction[31:20]};
    assign immS = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign immB = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
    assign immU = {instruction[31:12], 12'b0};
    assign immJ = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

    reg_file #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_regFile (
        .clk        (clk),
        .reset      (reset),
        .rs1_addr_i (rs1Dec),
        .rs2_addr_i (rs2Dec),
        .rs1_data_o (rs1Read),
        .rs2_data_o (rs2Read),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data)
    );

    always_comb begin
        ctrlDec = CTRL_NOP;
        opLegal = 1'b1;
        imm32   = '0;
        case (opcode)
            OP_LOAD: begin
                ctrlDec.aluSrc   = 1'b1;
                ctrlDec.memToReg = 1'b1;
                ctrlDec.regWrite = 1'b1;
                ctrlDec.memRead  = 1'b1;
                ctrlDec.aluOp    = ALU_ADD;
                imm32            = immI;
            end
            OP_STORE: begin
                ctrlDec.aluSrc   = 1'b1;
                ctrlDec.memWrite = 1'b1;
                ctrlDec.aluOp    = ALU_ADD;
                imm32            = immS;
            end
            OP_OP: begin
                ctrlDec.regWrite = 1'b1;
                ctrlDec.aluOp    = ALU_FUNC;
            end
            OP_IMM: begin
                ctrlDec.aluSrc   = 1'b1;
                ctrlDec.regWrite = 1'b1;
                ctrlDec.aluOp    = ALU_FUNC;
                imm32            = immI;
            end
            OP_BRANCH: begin
                ctrlDec.branch   = 1'b1;
                ctrlDec.aluOp    = ALU_BRANCH;
                imm32            = immB;
            end
            OP_LUI, OP_AUIPC: begin
                ctrlDec.aluSrc   = 1'b1;
                ctrlDec.regWrite = 1'b1;
                ctrlDec.aluOp    = ALU_UPPER;
                imm32            = immU;
            end
            OP_JAL, OP_JALR: begin
                ctrlDec.aluSrc   = 1'b1;
                ctrlDec.regWrite = 1'b1;
                ctrlDec.jump     = 1'b1;
                ctrlDec.aluOp    = ALU_ADD;
                imm32            = (opcode == OP_JAL) ? immJ : immI;
            end
            default: opLegal = 1'b0;
        endcase

        // Only fields the format actually uses can make a reduced (RV32E) register set illegal.
        regLegal = !((usesRs1(opcode)  && (int'(rs1Field) >= NUM_REGS)) ||
                     (usesRs2(opcode)  && (int'(rs2Field) >= NUM_REGS)) ||
                     (writesRd(opcode) && (int'(rdField)  >= NUM_REGS)));
        illegalDec = !(opLegal && regLegal);
        if (illegalDec) begin
            ctrlDec = CTRL_NOP;
        end
        immDec = XLEN'(imm32);
    end

    assign loadUse = valid_q && ctrl_q.memRead && (rd_q != '0) && valid_in &&
                     ((rd_q == rs1Dec) || (usesRs2(opcode) && (rd_q == rs2Dec)));
    assign advance   = ex_ready || !valid_q;
    assign ready_out = advance && !loadUse;

    // Killing a slot clears valid and the seven control bits; alu_op and the data fields hold.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        imm_d     = imm_q;
        rs1Data_d = rs1Data_q;
        rs2Data_d = rs2Data_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        func3_d   = func3_q;
        func7_d   = func7_q;
        pc_d      = pc_q;
        if (flush || (advance && (loadUse || !valid_in))) begin
            valid_d      = 1'b0;
            ctrl_d       = CTRL_NOP;
            ctrl_d.aluOp = ctrl_q.aluOp;
            illegal_d    = 1'b0;
        end else if (advance) begin
            valid_d   = 1'b1;
            ctrl_d    = ctrlDec;
            illegal_d = illegalDec;
            imm_d     = immDec;
            rs1Data_d = rs1Read;
            rs2Data_d = rs2Read;
            rs1_d     = rs1Dec;
            rs2_d     = rs2Dec;
            rd_d      = rdDec;
            func3_d   = instruction[14:12];
            func7_d   = instruction[31:25];
            pc_d      = pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
            imm_q     <= '0;
            rs1Data_q <= '0;
            rs2Data_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            func3_q   <= '0;
            func7_q   <= '0;
            pc_q      <= RESET_PC;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            imm_q     <= imm_d;
            rs1Data_q <= rs1Data_d;
            rs2Data_q <= rs2Data_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            func3_q   <= func3_d;
            func7_q   <= func7_d;
            pc_q      <= pc_d;
        end
    end

    assign valid_out  = valid_q;
    assign imm        = imm_q;
    assign rs1_data   = rs1Data_q;
    assign rs2_data   = rs2Data_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign rd         = rd_q;
    assign func3      = func3_q;
    assign func7      = func7_q;
    assign pc_out     = pc_q;
    assign alu_src    = ctrl_q.aluSrc;
    assign mem_to_reg = ctrl_q.memToReg;
    assign reg_write  = ctrl_q.regWrite;
    assign mem_read   = ctrl_q.memRead;
    assign mem_write  = ctrl_q.memWrite;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign alu_op     = ctrl_q.aluOp;
    assign illegal    = illegal_q;

endmodule
